// File: rtl/rggen_rwc_clear_scheduler_pkg.sv
// Shared definitions for the RWC clear scheduler: FSM state encodings,
// a ceiling-log2 helper and the completed-clear counter width.
package rggen_rwc_clear_scheduler_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'b00,
        STATE_ISSUE = 2'b01,
        STATE_ACK   = 2'b10
    } state_e;

    localparam int COUNT_WIDTH = 16;

    // Index width for a vector of the given size, never less than one bit.
    function automatic int rggen_clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rggen_rwc_clear_scheduler_rr_picker.sv
// Combinational round-robin select: lowest requesting index at or above the
// pointer, otherwise wraps around to the lowest requesting index overall.
module rggen_rr_picker #(
    parameter int REQUESTERS = 4,
    parameter int IDW        = 2
)(
    input  logic [REQUESTERS-1:0] i_request,
    input  logic [IDW-1:0]        i_pointer,
    output logic                  o_any,
    output logic [IDW-1:0]        o_index
);

    logic [REQUESTERS-1:0] masked_req_next;
    logic                  upper_found_next;
    logic [IDW-1:0]        upper_index_next;
    logic [IDW-1:0]        lower_index_next;

    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_mask
        assign masked_req_next[gi] = i_request[gi] && (IDW'(gi) >= i_pointer);
    end

    // Descending scan so the last hit is the lowest index.
    always_comb begin
        upper_found_next = 1'b0;
        upper_index_next = '0;
        lower_index_next = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (masked_req_next[i]) begin
                upper_found_next = 1'b1;
                upper_index_next = IDW'(i);
            end
            if (i_request[i]) begin
                lower_index_next = IDW'(i);
            end
        end
    end

    assign o_any   = |i_request;
    assign o_index = upper_found_next ? upper_index_next : lower_index_next;

endmodule

// File: rtl/rggen_rwc_clear_scheduler.sv
// Shares one RWC field clear among several requesters with round-robin
// arbitration; reissues clears lost to a colliding bus write.
// Optional completed-clear counter: RGGEN_RWC_CLEAR_SCHEDULER_COUNT_EN.
module rggen_rwc_clear_scheduler
    import rggen_rwc_clear_scheduler_pkg::*;
#(
    parameter int   REQUESTERS  = 4,
    parameter int   WIDTH       = 8,
    parameter int   WRITE_FIRST = 1,
    parameter int   MAX_DEFER   = 15,
    localparam int  IDW         = rggen_clog2(REQUESTERS)
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [REQUESTERS-1:0]  i_clear_request,
    output logic [REQUESTERS-1:0]  o_clear_ack,
    output logic [IDW-1:0]         o_grant_id,
    input  logic                   i_bit_field_valid,
    input  logic [WIDTH-1:0]       i_bit_field_write_mask,
    output logic                   o_clear,
    output logic                   o_busy,
    output logic                   o_defer_error,
    output logic [COUNT_WIDTH-1:0] o_clear_count
);

    localparam bit WRITE_FIRST_EN = (WRITE_FIRST != 0);

    state_e         state_reg;
    logic [IDW-1:0] grant_id_reg;
    logic [IDW-1:0] pointer_reg;
    logic [7:0]     defer_count_reg;
    logic           defer_error_reg;

    logic           any_request_next;
    logic [IDW-1:0] pick_index_next;
    logic [IDW-1:0] pointer_next;
    logic           collision_next;

    rggen_rr_picker #(
        .REQUESTERS (REQUESTERS),
        .IDW        (IDW)
    ) u_picker (
        .i_request  (i_clear_request),
        .i_pointer  (pointer_reg),
        .o_any      (any_request_next),
        .o_index    (pick_index_next)
    );

    // A write that wins over the clear means the field never saw the clear.
    assign collision_next = WRITE_FIRST_EN && i_bit_field_valid && (|i_bit_field_write_mask);
    assign pointer_next   = (grant_id_reg == IDW'(REQUESTERS - 1)) ? '0 : grant_id_reg + IDW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= STATE_IDLE;
            grant_id_reg    <= '0;
            pointer_reg     <= '0;
            defer_count_reg <= '0;
            defer_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                STATE_IDLE: begin
                    if (any_request_next) begin
                        grant_id_reg <= pick_index_next;
                        state_reg    <= STATE_ISSUE;
                    end
                end
                STATE_ISSUE: begin
                    if (collision_next) begin
                        if (defer_count_reg != 8'(MAX_DEFER)) begin
                            defer_count_reg <= defer_count_reg + 8'd1;
                        end
                        if (defer_count_reg >= 8'(MAX_DEFER - 1)) begin
                            defer_error_reg <= 1'b1;
                        end
                    end else begin
                        state_reg <= STATE_ACK;
                    end
                end
                STATE_ACK: begin
                    pointer_reg     <= pointer_next;
                    defer_count_reg <= '0;
                    state_reg       <= STATE_IDLE;
                end
                default: begin
                    state_reg <= STATE_IDLE;
                end
            endcase
        end
    end

    assign o_grant_id    = grant_id_reg;
    assign o_clear       = (state_reg == STATE_ISSUE);
    assign o_busy        = (state_reg != STATE_IDLE);
    assign o_defer_error = defer_error_reg;
    assign o_clear_ack   = REQUESTERS'(state_reg == STATE_ACK) << grant_id_reg;

`ifdef RGGEN_RWC_CLEAR_SCHEDULER_COUNT_EN
    logic [COUNT_WIDTH-1:0] clear_count_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clear_count_reg <= '0;
        end else if (state_reg == STATE_ACK) begin
            clear_count_reg <= clear_count_reg + COUNT_WIDTH'(1);
        end
    end

    assign o_clear_count = clear_count_reg;
`else
    assign o_clear_count = '0;
`endif

endmodule

// File: tb/tb_rggen_rwc_clear_scheduler.sv
// Directed bench for the RWC clear scheduler: expected acks are queued as
// stimulus is driven and matched against the DUT by a negedge monitor.
module tb_rggen_rwc_clear_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_b;
    logic        valid;
    logic [7:0]  mask;

    logic [3:0]  ack,   ack_b;
    logic [1:0]  gid,   gid_b;
    logic        clr,   clr_b;
    logic        busy,  busy_b;
    logic        err,   err_b;
    logic [15:0] cnt,   cnt_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_count = 0;
    int c;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
        logic [1:0] gid;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rggen_rwc_clear_scheduler #(
        .REQUESTERS (4), .WIDTH (8), .WRITE_FIRST (1), .MAX_DEFER (3)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_clear_request (req), .o_clear_ack (ack),
        .o_grant_id (gid), .i_bit_field_valid (valid), .i_bit_field_write_mask (mask),
        .o_clear (clr), .o_busy (busy), .o_defer_error (err), .o_clear_count (cnt)
    );

    rggen_rwc_clear_scheduler #(
        .REQUESTERS (4), .WIDTH (8), .WRITE_FIRST (0), .MAX_DEFER (3)
    ) dut_b (
        .i_clk (clk), .i_rst (rst), .i_clear_request (req_b), .o_clear_ack (ack_b),
        .o_grant_id (gid_b), .i_bit_field_valid (valid), .i_bit_field_write_mask (mask),
        .o_clear (clr_b), .o_busy (busy_b), .o_defer_error (err_b), .o_clear_count (cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [3:0] vec, input logic [1:0] g);
        exp_t e;
        e.cyc = at;
        e.vec = vec;
        e.gid = g;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] exp_count();
`ifdef RGGEN_RWC_CLEAR_SCHEDULER_COUNT_EN
        return 32'(done_count[15:0]);
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard: any ack, or any cycle at which an ack is due, pops one entry.
    always @(negedge clk) begin
        if ((|ack) === 1'b1 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("ack cyc=%0d vec=%b gid=%0d (want cyc=%0d vec=%b gid=%0d)",
                         cyc, ack, gid, mon_e.cyc, mon_e.vec, mon_e.gid);
                check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("ack_vec", 32'(ack), 32'(mon_e.vec));
                check("ack_gid", 32'(gid), 32'(mon_e.gid));
                done_count++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; req_b = '0; valid = 1'b0; mask = '0;
        tick(3);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_gid", 32'(gid), 32'd0);
        check("rst_clear", 32'(clr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;

        // All four held: round-robin 0,1,2,3,0, one ack every 3 cycles.
        c = cyc;
        req = 4'b1111;
        push(c + 2, 4'b0001, 2'd0);
        push(c + 5, 4'b0010, 2'd1);
        push(c + 8, 4'b0100, 2'd2);
        push(c + 11, 4'b1000, 2'd3);
        push(c + 14, 4'b0001, 2'd0);
        tick(1);
        check("rr_clear", 32'(clr), 32'd1);
        check("rr_busy", 32'(busy), 32'd1);
        tick(13);
        req = '0;
        tick(1);
        check("rr_idle", 32'(busy), 32'd0);
        check("rr_count", 32'(cnt), exp_count());

        // Single request from client 2 (pointer currently 1).
        c = cyc;
        req = 4'b0100;
        push(c + 2, 4'b0100, 2'd2);
        tick(1);
        check("single_clear", 32'(clr), 32'd1);
        check("single_gid", 32'(gid), 32'd2);
        tick(1);
        req = '0;
        tick(1);
        check("single_idle", 32'(busy), 32'd0);

        // Pointer now 3: client 3 beats client 0, then 0 is served.
        c = cyc;
        req = 4'b1001;
        push(c + 2, 4'b1000, 2'd3);
        push(c + 5, 4'b0001, 2'd0);
        tick(2);
        req = 4'b0001;
        tick(3);
        req = '0;
        tick(1);
        check("ptr_idle", 32'(busy), 32'd0);

        // Two colliding writes defer the clear; WRITE_FIRST=0 instance ignores them.
        c = cyc;
        req = 4'b0010;
        req_b = 4'b0001;
        push(c + 4, 4'b0010, 2'd1);
        tick(1);
        valid = 1'b1; mask = 8'h01;
        check("col_clear1", 32'(clr), 32'd1);
        check("col_b_clear", 32'(clr_b), 32'd1);
        tick(1);
        check("col_clear2", 32'(clr), 32'd1);
        check("col_b_ack", 32'(ack_b), 32'b0001);
        check("col_b_err", 32'(err_b), 32'd0);
        req_b = '0;
        tick(1);
        valid = 1'b0; mask = '0;
        check("col_clear3", 32'(clr), 32'd1);
        tick(1);
        check("col_err", 32'(err), 32'd0);
        check("col_clear_off", 32'(clr), 32'd0);
        req = '0;
        tick(1);
        check("col_idle", 32'(busy), 32'd0);

        // Five colliding writes: error rises after the third deferral and sticks.
        c = cyc;
        req = 4'b0100;
        push(c + 7, 4'b0100, 2'd2);
        tick(1);
        valid = 1'b1; mask = 8'h01;
        tick(2);
        check("def_err_before", 32'(err), 32'd0);
        check("def_clear", 32'(clr), 32'd1);
        tick(1);
        check("def_err_set", 32'(err), 32'd1);
        tick(2);
        valid = 1'b0; mask = '0;
        check("def_still_issue", 32'(clr), 32'd1);
        tick(1);
        req = '0;
        tick(1);
        check("def_err_sticky", 32'(err), 32'd1);
        check("def_idle", 32'(busy), 32'd0);
        check("def_count", 32'(cnt), exp_count());

        // Reset during ISSUE: no ack, outputs cleared, held request re-served.
        c = cyc;
        req = 4'b0010;
        tick(1);
        check("mid_clear", 32'(clr), 32'd1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_clear", 32'(clr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_gid", 32'(gid), 32'd0);
        check("mid_rst_count", 32'(cnt), 32'd0);
        rst = 1'b0;
        done_count = 0;
        c = cyc;
        push(c + 2, 4'b0010, 2'd1);
        tick(1);
        check("post_rst_clear", 32'(clr), 32'd1);
        check("post_rst_gid", 32'(gid), 32'd1);
        tick(1);
        req = '0;
        tick(1);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_count", 32'(cnt), exp_count());

        tick(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
